// File: rtl/eab_pipe.sv
// eab_pipe: pipelined effective-address adder with an output FIFO.
//
// Each accepted request adds a base (pc or ra) to a sign-extended, optionally
// x2-scaled offset taken from ir. Stage 1 registers the operands. Stage 2 adds
// them and pushes the sum into a DEPTH-entry FIFO. The FIFO is drained through
// a valid/ready handshake.
//
// Optional feature macro: EAB_WRAP_FLAG_EN
//   When defined, each FIFO entry also stores a wrap bit and drives it on
//   out_wrap. The bit is set when the exact signed sum falls outside
//   0..2^WIDTH-1.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   flush              synchronous drop of the stage register and FIFO contents
//   in_valid/in_ready  request handshake
//   pc, ra             base candidates; sel_eab1 picks ra when set
//   ir                 instruction bits [10:0] holding the offset fields
//   sel_eab2           offset select: zero, ir[5:0], ir[8:0] or ir[10:0]
//   sel_scale          shift the offset left by one before the add
//   out_valid/out_ready, out_addr, out_wrap   FIFO head handshake and data
module eab_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] ra,
    input  logic [10:0]      ir,
    input  logic             sel_eab1,
    input  logic [1:0]       sel_eab2,
    input  logic             sel_scale,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef EAB_WRAP_FLAG_EN
    output logic             out_wrap,
`endif
    output logic [WIDTH-1:0] out_addr
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_base_q, s1_base_d;
    logic [WIDTH-1:0] s1_off_q, s1_off_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic [WIDTH-1:0] off_sext, off_scaled;
    logic [WIDTH-1:0] sum;
    logic [CW:0]      occupancy;
    logic             accept, push, pop;

    // Stage 1 operand selection
    always_comb begin
        off_sext = '0;
        unique case (sel_eab2)
            2'b00: off_sext = '0;
            2'b01: off_sext = {{(WIDTH - 6){ir[5]}}, ir[5:0]};
            2'b10: off_sext = {{(WIDTH - 9){ir[8]}}, ir[8:0]};
            2'b11: off_sext = {{(WIDTH - 11){ir[10]}}, ir[10:0]};
        endcase
        off_scaled = sel_scale ? {off_sext[WIDTH-2:0], 1'b0} : off_sext;
    end

    // Handshakes. in_ready never looks at out_ready. Stage 1 is counted as
    // occupied, so a push from it always has a free slot.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, s1_valid_q};
    assign in_ready  = !flush && (occupancy < (CW + 1)'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = s1_valid_q && !flush;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready && !flush;
    assign out_addr  = mem_q[rd_ptr_q];

`ifdef EAB_WRAP_FLAG_EN
    logic             wrap_q [DEPTH];
    logic [WIDTH:0]   sum_ext;
    logic             wrap;

    // Unsigned carry disagreeing with the offset sign means the exact sum left range
    assign sum_ext  = {1'b0, s1_base_q} + {1'b0, s1_off_q};
    assign sum      = sum_ext[WIDTH-1:0];
    assign wrap     = sum_ext[WIDTH] ^ s1_off_q[WIDTH-1];
    assign out_wrap = wrap_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) wrap_q[i] <= 1'b0;
        end else if (push) begin
            wrap_q[wr_ptr_q] <= wrap;
        end
    end
`else
    assign sum = s1_base_q + s1_off_q;
`endif

    // Next-state logic
    always_comb begin
        s1_valid_d = accept;
        s1_base_d  = s1_base_q;
        s1_off_d   = s1_off_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (accept) begin
            s1_base_d = sel_eab1 ? ra : pc;
            s1_off_d  = off_scaled;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
            if (push && !pop) count_d = count_q + CW'(1);
            if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_base_q  <= '0;
            s1_off_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_base_q  <= s1_base_d;
            s1_off_q   <= s1_off_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage is reset so out_addr reads zero straight out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= sum;
        end
    end

endmodule

// File: tb/tb_eab_pipe.sv
module tb_eab_pipe;

    localparam int W = 16;
    localparam int D = 4;
    localparam longint M = 64'd1 << W;

    typedef struct {
        logic [W-1:0] addr;
        logic         wrap;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] pc = '0;
    logic [W-1:0] ra = '0;
    logic [10:0]  ir = '0;
    logic         sel_eab1 = 1'b0;
    logic [1:0]   sel_eab2 = 2'b00;
    logic         sel_scale = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_addr;
`ifdef EAB_WRAP_FLAG_EN
    logic         out_wrap;
`endif

    eab_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc        (pc),
        .ra        (ra),
        .ir        (ir),
        .sel_eab1  (sel_eab1),
        .sel_eab2  (sel_eab2),
        .sel_scale (sel_scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef EAB_WRAP_FLAG_EN
        .out_wrap  (out_wrap),
`endif
        .out_addr  (out_addr)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    bit   s1v = 1'b0;
    ent_t s1e;
    bit   last_ov;
    bit   last_ir;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact integer sum, then reduce modulo 2^W
    function automatic ent_t ref_ea();
        ent_t   e;
        longint base, off, exact;
        base = sel_eab1 ? longint'(ra) : longint'(pc);
        case (sel_eab2)
            2'd1:    off = ir[5]  ? longint'(ir[5:0]) - 64   : longint'(ir[5:0]);
            2'd2:    off = ir[8]  ? longint'(ir[8:0]) - 512  : longint'(ir[8:0]);
            2'd3:    off = ir[10] ? longint'(ir[10:0]) - 2048 : longint'(ir[10:0]);
            default: off = 0;
        endcase
        if (sel_scale) off = off * 2;
        exact  = base + off;
        e.addr = W'(((exact % M) + M) % M);
        e.wrap = (exact < 0) || (exact >= M);
        return e;
    endfunction

    // One clock cycle: compare outputs mid-cycle, then advance the model at the edge
    task automatic tick();
        bit   exp_ready, acc, pop, push;
        ent_t ne;
        #3;
        exp_ready = !flush && ((q.size() + int'(s1v)) < D);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        check("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            check("out_addr", {16'd0, out_addr}, {16'd0, q[0].addr});
`ifdef EAB_WRAP_FLAG_EN
            check("out_wrap", {31'd0, out_wrap}, {31'd0, q[0].wrap});
`endif
        end
        last_ov = out_valid;
        last_ir = in_ready;
        acc  = in_valid && exp_ready;
        pop  = !flush && (q.size() != 0) && out_ready;
        push = !flush && s1v;
        ne   = ref_ea();
        @(posedge clk);
        if (flush) begin
            q.delete();
            s1v = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(s1e);
            s1v = acc;
            s1e = ne;
        end
        #1;
    endtask

    task automatic rand_req();
        pc        = W'($urandom);
        ra        = W'($urandom);
        ir        = 11'($urandom);
        sel_eab1  = 1'($urandom);
        sel_eab2  = 2'($urandom);
        sel_scale = 1'($urandom);
    endtask

    // Present one request into an empty pipe, check it two edges later, drain it
    task automatic directed(input string tag, input logic [W-1:0] exp_addr, input logic exp_wrap);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #3;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_addr"}, {16'd0, out_addr}, {16'd0, exp_addr});
`ifdef EAB_WRAP_FLAG_EN
        check({tag, "_wrap"}, {31'd0, out_wrap}, {31'd0, exp_wrap});
`else
        if (exp_wrap === 1'bx) checks += 0;
`endif
        #1;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        int run, maxrun, nacc, nout;

        // Reset state
        #3;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_addr", {16'd0, out_addr}, 32'd0);
`ifdef EAB_WRAP_FLAG_EN
        check("rst_out_wrap", {31'd0, out_wrap}, 32'd0);
`endif
        #4 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic add with pc base
        pc = 16'h3000; sel_eab1 = 1'b0; sel_eab2 = 2'b10; ir = 11'h1FF; sel_scale = 1'b0;
        directed("pc_base", 16'h2FFF, 1'b0);

        // ra base with scaled offset
        ra = 16'h0010; sel_eab1 = 1'b1; sel_eab2 = 2'b01; ir = 11'h005; sel_scale = 1'b1;
        directed("ra_scaled", 16'h001A, 1'b0);

        // Address wraps past the top
        pc = 16'hFFFF; sel_eab1 = 1'b0; sel_eab2 = 2'b01; ir = 11'h001; sel_scale = 1'b0;
        directed("wrap", 16'h0000, 1'b1);

        // Backpressure: 6 requests offered with out_ready low, only 4 fit
        out_ready = 1'b0;
        in_valid  = 1'b1;
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            rand_req();
            tick();
            if (last_ir) nacc++;
        end
        check("bp_accepts", nacc, 32'd4);
        #3;
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        nout = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (last_ov) nout++;
        end
        check("bp_drained", nout, 32'd4);

        // Full throughput: 8 back-to-back requests
        out_ready = 1'b1;
        in_valid  = 1'b1;
        nacc = 0;
        run = 0;
        maxrun = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) in_valid = 1'b0;
            rand_req();
            tick();
            if (in_valid && last_ir) nacc++;
            run    = last_ov ? run + 1 : 0;
            maxrun = (run > maxrun) ? run : maxrun;
        end
        check("thru_accepts", nacc, 32'd8);
        check("thru_valid_run", maxrun, 32'd8);

        // Flush with 3 entries queued
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_req();
            tick();
        end
        in_valid = 1'b0;
        tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        rand_req();
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        #3;
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_in_ready", {31'd0, in_ready}, 32'd1);
        #1;
        tick();

        // Asynchronous reset mid-stream
        in_valid  = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_req();
            tick();
        end
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_addr", {16'd0, out_addr}, 32'd0);
`ifdef EAB_WRAP_FLAG_EN
        check("arst_out_wrap", {31'd0, out_wrap}, 32'd0);
`endif
        q.delete();
        s1v = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            rand_req();
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 25) == 0;
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
